// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers pixel coordinates from hs/vs/active_nblank,
// measures line and frame timing and locks when it matches the parameters.
// Ports:
//   pixel_clk, reset_rtl_0 (sync, active-low)   clock and reset
//   hs, vs (active-low), active_nblank          raw video timing inputs
//   drawX, drawY, pixel_valid                   recovered pixel position, 2-cycle lag
//   frame_start                                 one-cycle pulse per vs falling edge
//   locked                                      timing matches the parameters
//   line_len, frame_lines, err_count            timing statistics
// Optional feature: define VGA_SYNC_DECODER_STATS_EN to enable line_len,
// frame_lines and err_count; without it they are tied to 0.
`timescale 1ns/1ps
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic       pixel_clk,
  input  logic       reset_rtl_0,
  input  logic       hs,
  input  logic       vs,
  input  logic       active_nblank,
  output logic [9:0] drawX,
  output logic [9:0] drawY,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       locked,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic [7:0] err_count
);

  localparam int unsigned CW = 10;
  localparam int unsigned MW = CW + 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED, LOST} state_e;

  state_e        state_q, state_d;
  logic          hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d, de_s1_q, de_s1_d;
  logic          hs_s2_q, hs_s2_d, vs_s2_q, vs_s2_d, de_s2_q, de_s2_d;
  logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CW-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [CW-1:0] draw_x_q, draw_x_d, draw_y_q, draw_y_d;
  logic          pixel_valid_q, pixel_valid_d;
  logic          frame_start_q, frame_start_d;
  logic          locked_q, locked_d;

  logic          hs_fall, vs_fall, de_fall;
  logic [MW-1:0] h_meas;
  logic [CW-1:0] y_act;
  logic          line_err, frame_ok, timeout;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  // Edge detection against the second registered copy of each input
  assign hs_fall = hs_s2_q & ~hs_s1_q;
  assign vs_fall = vs_s2_q & ~vs_s1_q;
  assign de_fall = de_s2_q & ~de_s1_q;

  // Line length including the clock of the closing hs fall (11 bits to avoid wrap)
  assign h_meas   = {1'b0, h_cnt_q} + MW'(1);
  // Active lines seen so far, counting an active_nblank fall in this same cycle
  assign y_act    = de_fall ? sat_inc(y_cnt_q) : y_cnt_q;
  assign line_err = hs_fall &
                    ((h_meas != MW'(H_TOTAL)) ||
                     ((x_cnt_q != '0) && (x_cnt_q != CW'(H_ACTIVE))));
  assign frame_ok = (v_cnt_q == CW'(V_TOTAL)) && (y_act == CW'(V_ACTIVE));
  assign timeout  = (h_cnt_q == CNT_MAX);

  // Next-state, counters and registered outputs
  always_comb begin
    state_d       = state_q;
    hs_s1_d       = hs;
    vs_s1_d       = vs;
    de_s1_d       = active_nblank;
    hs_s2_d       = hs_s1_q;
    vs_s2_d       = vs_s1_q;
    de_s2_d       = de_s1_q;
    h_cnt_d       = hs_fall ? '0 : sat_inc(h_cnt_q);
    v_cnt_d       = v_cnt_q;
    x_cnt_d       = x_cnt_q;
    y_cnt_d       = y_cnt_q;
    pixel_valid_d = de_s1_q && (state_q == LOCKED);
    draw_x_d      = '0;
    draw_y_d      = '0;
    frame_start_d = vs_fall;

    // vs fall takes priority over a coincident hs fall
    if (vs_fall)      v_cnt_d = '0;
    else if (hs_fall) v_cnt_d = sat_inc(v_cnt_q);

    if (hs_fall)      x_cnt_d = '0;
    else if (de_s1_q) x_cnt_d = sat_inc(x_cnt_q);

    if (vs_fall)      y_cnt_d = '0;
    else if (de_fall) y_cnt_d = sat_inc(y_cnt_q);

    if (pixel_valid_d) begin
      draw_x_d = x_cnt_q;
      draw_y_d = y_cnt_q;
    end

    // Missing hs overrides everything else
    if (timeout) begin
      state_d = SEARCH;
    end else begin
      unique case (state_q)
        SEARCH:  if (vs_fall) state_d = MEASURE;
        MEASURE: begin
          if (line_err)     state_d = SEARCH;
          else if (vs_fall) state_d = frame_ok ? LOCKED : SEARCH;
        end
        LOCKED:  if (line_err || (vs_fall && !frame_ok)) state_d = LOST;
        LOST:    if (vs_fall) state_d = MEASURE;
        default: state_d = SEARCH;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset_rtl_0) begin
      state_q       <= SEARCH;
      hs_s1_q       <= 1'b0;
      vs_s1_q       <= 1'b0;
      de_s1_q       <= 1'b0;
      hs_s2_q       <= 1'b0;
      vs_s2_q       <= 1'b0;
      de_s2_q       <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      draw_x_q      <= '0;
      draw_y_q      <= '0;
      pixel_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_s1_q       <= hs_s1_d;
      vs_s1_q       <= vs_s1_d;
      de_s1_q       <= de_s1_d;
      hs_s2_q       <= hs_s2_d;
      vs_s2_q       <= vs_s2_d;
      de_s2_q       <= de_s2_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      draw_x_q      <= draw_x_d;
      draw_y_q      <= draw_y_d;
      pixel_valid_q <= pixel_valid_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
    end
  end

  assign drawX       = draw_x_q;
  assign drawY       = draw_y_q;
  assign pixel_valid = pixel_valid_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;

`ifdef VGA_SYNC_DECODER_STATS_EN
  logic [CW-1:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
  logic [7:0]    err_count_q, err_count_d;

  // Statistics; every exit from LOCKED is a timing error
  always_comb begin
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    err_count_d   = err_count_q;
    if (hs_fall) line_len_d = h_meas[CW] ? CNT_MAX : h_meas[CW-1:0];
    if (vs_fall) frame_lines_d = v_cnt_q;
    if ((state_q == LOCKED) && (state_d != LOCKED) && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset_rtl_0) begin
      line_len_q    <= '0;
      frame_lines_q <= '0;
      err_count_q   <= '0;
    end else begin
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      err_count_q   <= err_count_d;
    end
  end

  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign err_count   = err_count_q;
`else
  assign line_len    = '0;
  assign frame_lines = '0;
  assign err_count   = '0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder. A reduced-timing instance covers
// lock, pixel recovery, lock loss, missing hs and reset; a tiny-timing
// instance is driven through 300 lock losses for err_count saturation.
`timescale 1ns/1ps
module tb_vga_sync_decoder;

  // Main instance timing (lines of 32 clocks, 120 lines per frame)
  localparam int MH_T = 32, MH_A = 16, MH_SS = 20, MH_SE = 24;
  localparam int MV_T = 120, MV_A = 104, MV_SS = 108, MV_SE = 110;
  // Tiny instance timing (8 clocks, 4 lines)
  localparam int SH_T = 8, SH_A = 4, SH_SS = 5, SH_SE = 7;
  localparam int SV_T = 4, SV_A = 2, SV_SS = 3, SV_SE = 4;
  localparam int HOLD_LEN = 1100;

`ifdef VGA_SYNC_DECODER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk, rst_n, hs_i, vs_i, de_i;
  logic [9:0] draw_x, draw_y, line_len, frame_lines;
  logic       valid, frame_start, locked;
  logic [7:0] err_count;
  logic [9:0] s_draw_x, s_draw_y, s_line_len, s_frame_lines;
  logic       s_valid, s_frame_start, s_locked;
  logic [7:0] s_err_count;

  int checks = 0;
  int errors = 0;
  int fs_cnt = 0;
  int e_err  = 0;
  int hook_kind = 0;
  int hook_line = -1;

  vga_sync_decoder #(.H_TOTAL(MH_T), .V_TOTAL(MV_T), .H_ACTIVE(MH_A), .V_ACTIVE(MV_A)) u_dut (
    .pixel_clk(clk), .reset_rtl_0(rst_n), .hs(hs_i), .vs(vs_i), .active_nblank(de_i),
    .drawX(draw_x), .drawY(draw_y), .pixel_valid(valid), .frame_start(frame_start),
    .locked(locked), .line_len(line_len), .frame_lines(frame_lines), .err_count(err_count));

  vga_sync_decoder #(.H_TOTAL(SH_T), .V_TOTAL(SV_T), .H_ACTIVE(SH_A), .V_ACTIVE(SV_A)) u_small (
    .pixel_clk(clk), .reset_rtl_0(rst_n), .hs(hs_i), .vs(vs_i), .active_nblank(de_i),
    .drawX(s_draw_x), .drawY(s_draw_y), .pixel_valid(s_valid), .frame_start(s_frame_start),
    .locked(s_locked), .line_len(s_line_len), .frame_lines(s_frame_lines), .err_count(s_err_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (frame_start) fs_cnt <= fs_cnt + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int st(input int v);
    return STATS ? v : 0;
  endfunction

  task automatic drive_frame(input int ht, input int ha, input int hss, input int hse,
                             input int vt, input int va, input int vss, input int vse,
                             input int stretch, input int hold);
    for (int v = 0; v < vt; v++) begin
      int len;
      bit vlow;
      vlow = (v >= vss) && (v < vse);
      len  = (v == hold) ? HOLD_LEN : ((v == stretch) ? ht + 1 : ht);
      for (int h = 0; h < len; h++) begin
        @(negedge clk);
        // Outputs seen here reflect the pixel driven two iterations ago
        if (v == hook_line) begin
          if (hook_kind == 1) begin
            if (h == 1) begin
              check_eq("lag_valid_pre", int'(valid), 0);
              check_eq("lag_x_pre", int'(draw_x), 0);
            end
            if (h == 2) begin
              check_eq("px0_x", int'(draw_x), 0);
              check_eq("px0_y", int'(draw_y), 100);
              check_eq("px0_valid", int'(valid), 1);
            end
            if (h == 5) begin
              check_eq("px3_x", int'(draw_x), 3);
              check_eq("px3_y", int'(draw_y), 100);
            end
          end else if (hook_kind == 2 && h == 1090) begin
            check_eq("hold_locked", int'(locked), 0);
            check_eq("hold_line_len", int'(line_len), st(MH_T));
            check_eq("hold_err", int'(err_count), st(e_err));
          end else if (hook_kind == 3) begin
            if (h == 8) rst_n = 1'b0;
            if (h == 9) begin
              check_eq("mrst_x", int'(draw_x), 0);
              check_eq("mrst_y", int'(draw_y), 0);
              check_eq("mrst_valid", int'(valid), 0);
              check_eq("mrst_locked", int'(locked), 0);
              check_eq("mrst_line_len", int'(line_len), 0);
              check_eq("mrst_frame_lines", int'(frame_lines), 0);
              check_eq("mrst_err", int'(err_count), 0);
              rst_n = 1'b1;
            end
          end
        end
        vs_i = ~vlow;
        if (v == hold) begin
          hs_i = 1'b1;
          de_i = 1'b0;
        end else begin
          hs_i = ~((h >= hss) && (h < hse));
          de_i = (v < va) && (h < ha);
        end
      end
    end
  endtask

  task automatic main_frame(input int stretch, input int hold);
    drive_frame(MH_T, MH_A, MH_SS, MH_SE, MV_T, MV_A, MV_SS, MV_SE, stretch, hold);
  endtask

  task automatic small_frame(input bit short_f);
    if (short_f) drive_frame(SH_T, SH_A, SH_SS, SH_SE, SV_T - 1, SV_A, SV_SS - 1, SV_SE - 1, -1, -1);
    else         drive_frame(SH_T, SH_A, SH_SS, SH_SE, SV_T, SV_A, SV_SS, SV_SE, -1, -1);
  endtask

  initial begin
    int fs0;
    hs_i = 1'b1; vs_i = 1'b1; de_i = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_x", int'(draw_x), 0);
    check_eq("rst_y", int'(draw_y), 0);
    check_eq("rst_valid", int'(valid), 0);
    check_eq("rst_frame_start", int'(frame_start), 0);
    check_eq("rst_locked", int'(locked), 0);
    check_eq("rst_line_len", int'(line_len), 0);
    check_eq("rst_frame_lines", int'(frame_lines), 0);
    check_eq("rst_err", int'(err_count), 0);
    rst_n = 1'b1;

    // Acquisition: first vs fall enters MEASURE, the next one locks
    main_frame(-1, -1);
    check_eq("f0_locked", int'(locked), 0);
    fs0 = fs_cnt;
    main_frame(-1, -1);
    check_eq("f1_locked", int'(locked), 1);
    check_eq("f1_line_len", int'(line_len), st(MH_T));
    check_eq("f1_frame_lines", int'(frame_lines), st(MV_T));
    check_eq("f1_err", int'(err_count), 0);
    check_eq("f1_frame_start_pulses", fs_cnt - fs0, 1);

    // First active pixel of line 100
    hook_kind = 1; hook_line = 100;
    main_frame(-1, -1);
    hook_kind = 0; hook_line = -1;
    check_eq("f2_locked", int'(locked), 1);

    // One line one clock too long
    main_frame(50, -1);
    e_err = 1;
    check_eq("stretch_locked", int'(locked), 0);
    check_eq("stretch_err", int'(err_count), st(e_err));
    main_frame(-1, -1);
    check_eq("relock_locked", int'(locked), 1);
    check_eq("relock_err", int'(err_count), st(e_err));

    // hs held high for 1100 clocks
    e_err = 2;
    hook_kind = 2; hook_line = 60;
    main_frame(-1, 60);
    hook_kind = 0; hook_line = -1;
    check_eq("hold_after_locked", int'(locked), 0);
    check_eq("hold_after_line_len", int'(line_len), st(MH_T));
    main_frame(-1, -1);
    check_eq("hold_relock", int'(locked), 1);

    // One-cycle reset mid-line 50
    hook_kind = 3; hook_line = 50;
    main_frame(-1, -1);
    hook_kind = 0; hook_line = -1;
    check_eq("mrst_frame_locked", int'(locked), 0);
    main_frame(-1, -1);
    check_eq("mrst_relock", int'(locked), 1);
    check_eq("mrst_relock_err", int'(err_count), 0);
    check_eq("mrst_relock_frame_lines", int'(frame_lines), st(MV_T));

    // Tiny instance: repeated lock losses by a short frame
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    small_frame(1'b0);
    small_frame(1'b0);
    check_eq("s_locked_init", int'(s_locked), 1);
    for (int i = 0; i < 300; i++) begin
      small_frame(1'b1);
      small_frame(1'b0);
      small_frame(1'b0);
      if (i == 0)   check_eq("s_err_1", int'(s_err_count), st(1));
      if (i == 253) check_eq("s_err_254", int'(s_err_count), st(254));
      if (i == 254) check_eq("s_err_255", int'(s_err_count), st(255));
    end
    check_eq("s_err_sat", int'(s_err_count), st(255));
    check_eq("s_locked_end", int'(s_locked), 1);
    check_eq("s_frame_lines", int'(s_frame_lines), st(SV_T));
    check_eq("s_line_len", int'(s_line_len), st(SH_T));
    check_eq("s_valid_blank", int'(s_valid), 0);
    check_eq("s_x_blank", int'(s_draw_x), 0);
    check_eq("s_y_blank", int'(s_draw_y), 0);
    check_eq("s_frame_start_low", int'(s_frame_start), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
